// File: rtl/polar_to_dec_fsm.sv
// polar_to_dec_fsm: iterative rotation-mode CORDIC that turns (magnitude, phase in degrees)
// into gain-compensated Cartesian (x, y). One conversion at a time.
// Phase format: signed 1/9/22 fixed point degrees (90 deg = 32'h1680_0000).
module polar_to_dec_fsm #(
    parameter int WIDTH   = 32,
    parameter int NSTAGES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_vld,
    input  logic signed [WIDTH-1:0] i_mag,
    input  logic signed [31:0]      i_phase,
    output logic                    ready,
    output logic                    o_vld,
    output logic signed [WIDTH-1:0] o_x,
    output logic signed [WIDTH-1:0] o_y
);

    // Two guard bits hold the CORDIC gain (~1.6468) without overflow.
    localparam int XW = WIDTH + 2;
    localparam int CW = $clog2(NSTAGES + 1);
    localparam int PW = XW + 16;

    localparam logic signed [31:0] DEG90   = 32'sh1680_0000;
    localparam logic signed [31:0] NEG90   = 32'shE980_0000;
    localparam logic signed [31:0] DEG180  = 32'sh2D00_0000;
    localparam logic signed [31:0] NEG180  = 32'shD300_0000;
    localparam logic signed [31:0] DEG360  = 32'sh5A00_0000;
    // 1/K in Q1.15 (0.607253).
    localparam logic signed [15:0] SCALE_K = 16'sd19898;

    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        SCALE  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic signed [XW-1:0]   x_q;
    logic signed [XW-1:0]   y_q;
    logic signed [31:0]     z_q;

    logic signed [XW-1:0]   mag_ext_d;
    logic signed [31:0]     z_norm_d;
    logic signed [XW-1:0]   x_pre_d;
    logic signed [XW-1:0]   y_pre_d;
    logic signed [31:0]     z_pre_d;

    logic signed [XW-1:0]   x_sh_d;
    logic signed [XW-1:0]   y_sh_d;
    logic signed [31:0]     atan_d;
    logic signed [XW-1:0]   x_nx_d;
    logic signed [XW-1:0]   y_nx_d;
    logic signed [31:0]     z_nx_d;

    logic signed [PW-1:0]   prod_x_d;
    logic signed [PW-1:0]   prod_y_d;
    logic signed [WIDTH-1:0] x_sat_d;
    logic signed [WIDTH-1:0] y_sat_d;

    // atan(2^-i) in 1/9/22 degrees, truncated.
    function automatic logic signed [31:0] atan_tab(input int idx);
        logic signed [31:0] v;
        case (idx)
            32'sd0:  v = 32'sh0B40_0000;
            32'sd1:  v = 32'sh06A4_29CC;
            32'sd2:  v = 32'sh0382_51D0;
            32'sd3:  v = 32'sh01C8_0044;
            32'sd4:  v = 32'sh00E4_E2A9;
            32'sd5:  v = 32'sh0072_8DE5;
            32'sd6:  v = 32'sh0039_4A86;
            32'sd7:  v = 32'sh001C_A5B5;
            32'sd8:  v = 32'sh000E_52E9;
            32'sd9:  v = 32'sh0007_2976;
            32'sd10: v = 32'sh0003_94BB;
            32'sd11: v = 32'sh0001_CA5D;
            32'sd12: v = 32'sh0000_E52E;
            32'sd13: v = 32'sh0000_7297;
            32'sd14: v = 32'sh0000_394B;
            32'sd15: v = 32'sh0000_1CA5;
            32'sd16: v = 32'sh0000_0E52;
            32'sd17: v = 32'sh0000_0729;
            default: v = 32'sh0000_0000;
        endcase
        return v;
    endfunction

    // Clamp a scaled product into the WIDTH-bit signed output range.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX;
        end else if (v < SAT_MIN) begin
            r = SAT_MIN;
        end else begin
            r = v;
        end
        return r[WIDTH-1:0];
    endfunction

    assign ready = (state_q == IDLE) | (state_q == OUTPUT);

    // Accept-cycle phase wrap into [-180,180) and quadrant pre-rotation to |z| <= 90.
    always_comb begin
        mag_ext_d = {{2{i_mag[WIDTH-1]}}, i_mag};
        z_norm_d  = i_phase;
        if (i_phase >= DEG180) begin
            z_norm_d = i_phase - DEG360;
        end else if (i_phase < NEG180) begin
            z_norm_d = i_phase + DEG360;
        end else begin
            z_norm_d = i_phase;
        end

        x_pre_d = mag_ext_d;
        y_pre_d = {XW{1'b0}};
        z_pre_d = z_norm_d;
        if (z_norm_d > DEG90) begin
            x_pre_d = {XW{1'b0}};
            y_pre_d = mag_ext_d;
            z_pre_d = z_norm_d - DEG90;
        end else if (z_norm_d < NEG90) begin
            x_pre_d = {XW{1'b0}};
            y_pre_d = -mag_ext_d;
            z_pre_d = z_norm_d + DEG90;
        end else begin
            x_pre_d = mag_ext_d;
            y_pre_d = {XW{1'b0}};
            z_pre_d = z_norm_d;
        end
    end

    // One CORDIC micro-rotation, direction chosen by the sign of the residual angle.
    always_comb begin
        x_sh_d = x_q >>> cnt_q;
        y_sh_d = y_q >>> cnt_q;
        atan_d = atan_tab(int'(cnt_q));
        if (!z_q[31]) begin
            x_nx_d = x_q - y_sh_d;
            y_nx_d = y_q + x_sh_d;
            z_nx_d = z_q - atan_d;
        end else begin
            x_nx_d = x_q + y_sh_d;
            y_nx_d = y_q - x_sh_d;
            z_nx_d = z_q + atan_d;
        end
    end

    // Gain compensation: multiply by 1/K in Q1.15, truncate, saturate.
    always_comb begin
        prod_x_d = PW'(x_q) * PW'(SCALE_K);
        prod_y_d = PW'(y_q) * PW'(SCALE_K);
        x_sat_d  = sat(prod_x_d >>> 5'd15);
        y_sat_d  = sat(prod_y_d >>> 5'd15);
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            x_q     <= {XW{1'b0}};
            y_q     <= {XW{1'b0}};
            z_q     <= 32'sh0000_0000;
            o_vld   <= 1'b0;
            o_x     <= {WIDTH{1'b0}};
            o_y     <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= {CW{1'b0}};
                    o_vld <= 1'b0;
                    if (i_vld) begin
                        x_q     <= x_pre_d;
                        y_q     <= y_pre_d;
                        z_q     <= z_pre_d;
                        state_q <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    o_vld <= 1'b0;
                    x_q   <= x_nx_d;
                    y_q   <= y_nx_d;
                    z_q   <= z_nx_d;
                    if (cnt_q == CW'(NSTAGES - 1)) begin
                        cnt_q   <= {CW{1'b0}};
                        state_q <= SCALE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= BUSY;
                    end
                end
                SCALE: begin
                    cnt_q   <= {CW{1'b0}};
                    o_x     <= x_sat_d;
                    o_y     <= y_sat_d;
                    o_vld   <= 1'b1;
                    state_q <= OUTPUT;
                end
                OUTPUT: begin
                    cnt_q <= {CW{1'b0}};
                    o_vld <= 1'b0;
                    if (i_vld) begin
                        x_q     <= x_pre_d;
                        y_q     <= y_pre_d;
                        z_q     <= z_pre_d;
                        state_q <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= {CW{1'b0}};
                    o_vld   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
